// File: rtl/mem_access.sv
// Memory-access stage: captures execute results, runs one data-memory load/store over
// req/gnt/rvalid, aligns/extends load data and hands a single-cycle result to writeback.
module mem_access #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int REG_NUM       = 32,
  parameter int TIMEOUT       = 64,
  localparam int RD_W         = $clog2(REG_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0]    i_alu_result,
  input  logic [DATA_WIDTH-1:0]    i_store_data,
  input  logic                     i_mem_read,
  input  logic                     i_mem_write,
  input  logic [2:0]               i_funct3,
  input  logic [RD_W-1:0]          i_rd,
  input  logic                     i_ecall,
  output logic                     o_dmem_req,
  output logic                     o_dmem_we,
  output logic [ADDRESS_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]               o_dmem_be,
  output logic [DATA_WIDTH-1:0]    o_dmem_wdata,
  input  logic                     i_dmem_gnt,
  input  logic                     i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]    i_dmem_rdata,
  output logic                     o_valid,
  output logic [ADDRESS_WIDTH-1:0] o_pc,
  output logic [RD_W-1:0]          o_rd,
  output logic [DATA_WIDTH-1:0]    o_wb_data,
  output logic                     o_misaligned,
  output logic                     o_bus_err,
  output logic                     o_ecall
);

  // state | meaning
  // IDLE  | ready for a new instruction from execute
  // REQ   | data-memory request outstanding, waiting for gnt
  // RESP  | load granted, waiting for rvalid (bounded by TIMEOUT)
  // DONE  | one-cycle result pulse to writeback
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [RD_W-1:0]          r_rd;
  logic                     r_ecall;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_store_data;
  logic                     r_we;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0]    r_wb_data;
  logic                     r_misaligned;
  logic                     r_bus_err;

  logic [1:0]               w_off;
  logic [DATA_WIDTH-1:0]    w_rshift;
  logic [DATA_WIDTH-1:0]    w_load_data;
  logic [3:0]               w_be;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic                     w_in_mem;
  logic                     w_in_mis;

  assign w_off = r_addr[1:0];

  // funct3[1:0]: 00 byte, 01 half, 1x word (reserved encodings fall into word)
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_store_data;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{r_store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{r_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rshift    = i_dmem_rdata >> {w_off, 3'b000};
    w_load_data = i_dmem_rdata;
    case (r_funct3[1:0])
      2'b00:   w_load_data = r_funct3[2] ? {24'd0, w_rshift[7:0]}
                                         : {{24{w_rshift[7]}}, w_rshift[7:0]};
      2'b01:   w_load_data = r_funct3[2] ? {16'd0, w_rshift[15:0]}
                                         : {{16{w_rshift[15]}}, w_rshift[15:0]};
      default: w_load_data = i_dmem_rdata;
    endcase
  end

  assign w_in_mem = i_mem_read | i_mem_write;

  always_comb begin
    w_in_mis = 1'b0;
    case (i_funct3[1:0])
      2'b00:   w_in_mis = 1'b0;
      2'b01:   w_in_mis = i_alu_result[0];
      default: w_in_mis = (i_alu_result[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_rd         <= '0;
      r_ecall      <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_wb_data    <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_pc         <= i_pc;
            r_rd         <= i_rd;
            r_ecall      <= i_ecall;
            r_funct3     <= i_funct3;
            r_addr       <= i_alu_result;
            r_store_data <= i_store_data;
            r_we         <= i_mem_write;
            r_cnt        <= '0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            if (!w_in_mem) begin
              r_wb_data <= i_alu_result;
              r_state   <= S_DONE;
            end else if (w_in_mis) begin
              r_wb_data    <= '0;
              r_misaligned <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_dmem_gnt) begin
            if (r_we) begin
              r_wb_data <= '0;
              r_state   <= S_DONE;
            end else begin
              r_cnt   <= '0;
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          // data arriving on the final allowed cycle wins over the timeout
          if (i_dmem_rvalid) begin
            r_wb_data <= w_load_data;
            r_state   <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_wb_data <= '0;
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_misaligned <= 1'b0;
          r_bus_err    <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready      = (r_state == S_IDLE);
  assign o_valid      = (r_state == S_DONE);
  assign o_dmem_req   = (r_state == S_REQ);
  assign o_dmem_we    = (r_state == S_REQ) & r_we;
  assign o_dmem_addr  = {r_addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign o_dmem_be    = w_be;
  assign o_dmem_wdata = w_wdata;
  assign o_pc         = r_pc;
  assign o_rd         = r_rd;
  assign o_ecall      = r_ecall;
  assign o_wb_data    = r_wb_data;
  assign o_misaligned = r_misaligned;
  assign o_bus_err    = r_bus_err;

endmodule
